fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 18 +
 rtl/pc_step_adder.sv | 11 +
 rtl/fetch_pc_unit.sv | 134 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// FETCH_ALIGN_CHECK_EN adds the HALT state used after a misaligned redirect.
package fetch_pkg;
  localparam int unsigned INSTR_BYTES  = 4;
  localparam int unsigned DEF_ADDR_W   = 64;
  localparam int unsigned DEF_INSTR_W  = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {
    ST_BOOT, ST_REQ, ST_WAIT, ST_DELIVER, ST_DRAIN, ST_HALT
  } fetch_state_e;
`else
  typedef enum logic [2:0] {
    ST_BOOT, ST_REQ, ST_WAIT, ST_DELIVER, ST_DRAIN
  } fetch_state_e;
`endif
endpackage

// File: rtl/pc_step_adder.sv
// Sequential next-PC incrementer: pc + INSTR_BYTES, wrapping modulo 2^ADDR_W.
module pc_step_adder
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);
  assign pc_next = pc + ADDR_W'(INSTR_BYTES);
endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem fetch, decode handshake.
// FETCH_ALIGN_CHECK_EN enables misaligned-redirect faulting and the HALT state.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [ADDR_W-1:0]  o_imem_req_addr,
  input  logic               i_imem_rsp_valid,
  input  logic [INSTR_W-1:0] i_imem_rsp_data,
  output logic               o_dec_valid,
  input  logic               i_dec_ready,
  output logic [INSTR_W-1:0] o_dec_instr,
  output logic [ADDR_W-1:0]  o_dec_pc,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_fetch_fault
);
  fetch_state_e      state;
  fetch_state_e      redir_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] redir_target;

  pc_step_adder #(.ADDR_W(ADDR_W)) u_step (
    .pc      (pc),
    .pc_next (pc_next)
  );

  assign o_imem_req_valid = (state == ST_REQ);
  assign o_imem_req_addr  = pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic pend_q;   // response still owed for a request squashed on the way into HALT
  logic misaligned;

  assign misaligned    = |i_redirect_pc[1:0];
  assign redir_target  = i_redirect_pc;
  assign o_fetch_fault = fault_q;
`else
  assign redir_target  = i_redirect_pc & ~ADDR_W'(3);
  assign o_fetch_fault = 1'b0;
`endif

  // Where a redirect lands depends on whether a response is still owed.
  always_comb begin
    redir_state = ST_REQ;
    case (state)
      ST_REQ:           redir_state = i_imem_req_ready ? ST_DRAIN : ST_REQ;
      ST_WAIT, ST_DRAIN: redir_state = i_imem_rsp_valid ? ST_REQ : ST_DRAIN;
`ifdef FETCH_ALIGN_CHECK_EN
      ST_HALT:          redir_state = (pend_q && !i_imem_rsp_valid) ? ST_DRAIN : ST_REQ;
`endif
      default:          redir_state = ST_REQ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      req_pc      <= '0;
      o_dec_valid <= 1'b0;
      o_dec_instr <= '0;
      o_dec_pc    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q     <= 1'b0;
      pend_q      <= 1'b0;
`endif
    end else begin
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
      if (i_redirect_valid) begin
        pc          <= redir_target;
        o_dec_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (misaligned) begin
          fault_q <= 1'b1;
          state   <= ST_HALT;
          pend_q  <= (redir_state == ST_DRAIN);
        end else begin
          state  <= redir_state;
          pend_q <= 1'b0;
        end
`else
        state <= redir_state;
`endif
      end else begin
        case (state)
          ST_BOOT: state <= ST_REQ;
          ST_REQ: begin
            if (i_imem_req_ready) begin
              req_pc <= pc;
              pc     <= pc_next;
              state  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (i_imem_rsp_valid) begin
              o_dec_instr <= i_imem_rsp_data;
              o_dec_pc    <= req_pc;
              o_dec_valid <= 1'b1;
              state       <= ST_DELIVER;
            end
          end
          ST_DELIVER: begin
            if (i_dec_ready) begin
              o_dec_valid <= 1'b0;
              state       <= ST_REQ;
            end
          end
          ST_DRAIN: begin
            if (i_imem_rsp_valid) state <= ST_REQ;
          end
`ifdef FETCH_ALIGN_CHECK_EN
          ST_HALT: begin
            if (i_imem_rsp_valid) pend_q <= 1'b0;
          end
`endif
          default: state <= ST_BOOT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; a second instance with RESET_PC near the top of
// the address space shares all inputs and exercises PC wrap-around.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready, rsp_valid, dec_ready, redir_valid;
  logic [31:0] rsp_data;
  logic [63:0] redir_pc;

  logic        a_req_valid, a_dec_valid, a_fault;
  logic [63:0] a_addr, a_dec_pc;
  logic [31:0] a_instr;
  logic        b_req_valid, b_dec_valid, b_fault;
  logic [63:0] b_addr, b_dec_pc;
  logic [31:0] b_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h1000)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req_valid(a_req_valid), .i_imem_req_ready(imem_ready), .o_imem_req_addr(a_addr),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .o_dec_valid(a_dec_valid), .i_dec_ready(dec_ready), .o_dec_instr(a_instr), .o_dec_pc(a_dec_pc),
    .i_redirect_valid(redir_valid), .i_redirect_pc(redir_pc), .o_fetch_fault(a_fault)
  );

  fetch_pc_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req_valid(b_req_valid), .i_imem_req_ready(imem_ready), .o_imem_req_addr(b_addr),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .o_dec_valid(b_dec_valid), .i_dec_ready(dec_ready), .o_dec_instr(b_instr), .o_dec_pc(b_dec_pc),
    .i_redirect_valid(redir_valid), .i_redirect_pc(redir_pc), .o_fetch_fault(b_fault)
  );

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; rsp_valid = 1'b0; dec_ready = 1'b0;
    redir_valid = 1'b0; rsp_data = '0; redir_pc = '0;
    repeat (2) @(negedge clk);
    checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0b exp 0", a_req_valid); end
    checks++; if (a_dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid got %0b exp 0", a_dec_valid); end
    checks++; if (a_instr !== 32'h0) begin errors++; $display("FAIL rst_dec_instr got %h exp 0", a_instr); end
    checks++; if (a_dec_pc !== 64'h0) begin errors++; $display("FAIL rst_dec_pc got %h exp 0", a_dec_pc); end
    checks++; if (a_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0b exp 0", a_fault); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %0b exp 1", a_req_valid); end
    checks++; if (a_addr !== 64'h1000) begin errors++; $display("FAIL first_req_addr got %h exp 1000", a_addr); end
  endtask

  // Ready imem, response one cycle after acceptance, decode always ready: 3 cycles/instr.
  task automatic test_sequential();
    logic [63:0] exp_b [3];
    exp_b[0] = 64'hFFFF_FFFF_FFFF_FFFC; exp_b[1] = 64'h0; exp_b[2] = 64'h4;
    dec_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      checks++; if (a_req_valid !== 1'b1) begin errors++; $display("FAIL seq_req_valid[%0d] got %0b exp 1", i, a_req_valid); end
      checks++; if (a_addr !== 64'h1000 + 64'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, a_addr, 64'h1000 + 64'(4 * i)); end
      checks++; if (b_addr !== exp_b[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, b_addr, exp_b[i]); end
      imem_ready = 1'b1;
      @(negedge clk);
      checks++; if (a_req_valid !== 1'b0 || a_dec_valid !== 1'b0) begin errors++; $display("FAIL seq_wait[%0d] got req=%0b dec=%0b exp 0 0", i, a_req_valid, a_dec_valid); end
      imem_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hA000_0000 + i;
      @(negedge clk);
      rsp_valid = 1'b0;
      checks++; if (a_dec_valid !== 1'b1) begin errors++; $display("FAIL seq_dec_valid[%0d] got %0b exp 1", i, a_dec_valid); end
      checks++; if (a_instr !== 32'hA000_0000 + i) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, a_instr, 32'hA000_0000 + i); end
      checks++; if (a_dec_pc !== 64'h1000 + 64'(4 * i)) begin errors++; $display("FAIL seq_dec_pc[%0d] got %h exp %h", i, a_dec_pc, 64'h1000 + 64'(4 * i)); end
      checks++; if (b_dec_pc !== exp_b[i]) begin errors++; $display("FAIL wrap_dec_pc[%0d] got %h exp %h", i, b_dec_pc, exp_b[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h1234_5678; dec_ready = 1'b0;
    @(negedge clk);
    rsp_valid = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (a_dec_valid !== 1'b1 || a_instr !== 32'h1234_5678 || a_dec_pc !== 64'h100C)
        begin errors++; $display("FAIL stall_hold[%0d] got v=%0b i=%h pc=%h exp 1 12345678 100c", k, a_dec_valid, a_instr, a_dec_pc); end
      checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req[%0d] got %0b exp 0", k, a_req_valid); end
    end
    dec_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_req_valid !== 1'b1 || a_addr !== 64'h1010 || a_dec_valid !== 1'b0)
      begin errors++; $display("FAIL stall_release got req=%0b addr=%h dec=%0b exp 1 1010 0", a_req_valid, a_addr, a_dec_valid); end
  endtask

  task automatic test_redirect_wait();
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0; redir_valid = 1'b1; redir_pc = 64'h2000;
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL drain_no_req got %0b exp 0", a_req_valid); end
    @(negedge clk);
    checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL drain_hold got %0b exp 0", a_req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rsp_valid = 1'b0;
    checks++; if (a_dec_valid !== 1'b0) begin errors++; $display("FAIL drain_squash got %0b exp 0", a_dec_valid); end
    checks++; if (a_req_valid !== 1'b1 || a_addr !== 64'h2000) begin errors++; $display("FAIL drain_resume got req=%0b addr=%h exp 1 2000", a_req_valid, a_addr); end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0055;
    @(negedge clk);
    rsp_valid = 1'b0;
    checks++; if (a_dec_valid !== 1'b1 || a_instr !== 32'h55 || a_dec_pc !== 64'h2000)
      begin errors++; $display("FAIL redir_deliver got v=%0b i=%h pc=%h exp 1 55 2000", a_dec_valid, a_instr, a_dec_pc); end
    @(negedge clk);
  endtask

  task automatic test_redirect_rsp_same();
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0BAD_0BAD; redir_valid = 1'b1; redir_pc = 64'h3000;
    @(negedge clk);
    rsp_valid = 1'b0; redir_valid = 1'b0;
    checks++; if (a_dec_valid !== 1'b0) begin errors++; $display("FAIL same_rsp_drop got %0b exp 0", a_dec_valid); end
    checks++; if (a_req_valid !== 1'b1 || a_addr !== 64'h3000) begin errors++; $display("FAIL same_rsp_req got req=%0b addr=%h exp 1 3000", a_req_valid, a_addr); end
  endtask

  // Redirect in DELIVER with decode ready drops the held instruction; then redirect in REQ with ready.
  task automatic test_back_to_back();
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h7777_7777;
    @(negedge clk);
    rsp_valid = 1'b0; dec_ready = 1'b1; redir_valid = 1'b1; redir_pc = 64'h4004;
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (a_dec_valid !== 1'b0 || a_req_valid !== 1'b1 || a_addr !== 64'h4004)
      begin errors++; $display("FAIL deliver_redir got dec=%0b req=%0b addr=%h exp 0 1 4004", a_dec_valid, a_req_valid, a_addr); end
    imem_ready = 1'b1; redir_valid = 1'b1; redir_pc = 64'h5000;
    @(negedge clk);
    imem_ready = 1'b0; redir_valid = 1'b0;
    checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL req_ready_redir got %0b exp 0", a_req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
    @(negedge clk);
    rsp_valid = 1'b0;
    checks++; if (a_req_valid !== 1'b1 || a_addr !== 64'h5000 || a_dec_valid !== 1'b0)
      begin errors++; $display("FAIL req_ready_resume got req=%0b addr=%h dec=%0b exp 1 5000 0", a_req_valid, a_addr, a_dec_valid); end
  endtask

  task automatic test_align();
`ifdef FETCH_ALIGN_CHECK_EN
    redir_valid = 1'b1; redir_pc = 64'h2002;
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (a_fault !== 1'b1 || a_req_valid !== 1'b0) begin errors++; $display("FAIL align_fault got f=%0b req=%0b exp 1 0", a_fault, a_req_valid); end
    @(negedge clk);
    checks++; if (a_fault !== 1'b0 || a_req_valid !== 1'b0) begin errors++; $display("FAIL align_halt got f=%0b req=%0b exp 0 0", a_fault, a_req_valid); end
    redir_valid = 1'b1; redir_pc = 64'h2004;
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (a_req_valid !== 1'b1 || a_addr !== 64'h2004) begin errors++; $display("FAIL align_resume got req=%0b addr=%h exp 1 2004", a_req_valid, a_addr); end
`else
    redir_valid = 1'b1; redir_pc = 64'h2002;
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (a_fault !== 1'b0) begin errors++; $display("FAIL align_no_fault got %0b exp 0", a_fault); end
    checks++; if (a_req_valid !== 1'b1 || a_addr !== 64'h2000) begin errors++; $display("FAIL align_force got req=%0b addr=%h exp 1 2000", a_req_valid, a_addr); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp_same();
    test_back_to_back();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
